// File: rtl/copperv_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between the copperv instruction and data masters.
// One read is outstanding at a time; the data master's write channels pass straight through.
module copperv_bus_arbiter #(
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_raddr_valid,
    input  logic [BUS_WIDTH-1:0] i_raddr,
    output logic                 i_raddr_ready,
    output logic                 i_rdata_valid,
    output logic [BUS_WIDTH-1:0] i_rdata,
    input  logic                 i_rdata_ready,
    input  logic                 d_raddr_valid,
    input  logic [BUS_WIDTH-1:0] d_raddr,
    output logic                 d_raddr_ready,
    output logic                 d_rdata_valid,
    output logic [BUS_WIDTH-1:0] d_rdata,
    input  logic                 d_rdata_ready,
    input  logic                 d_waddr_valid,
    input  logic [BUS_WIDTH-1:0] d_waddr,
    output logic                 d_waddr_ready,
    input  logic                 d_wdata_valid,
    input  logic [BUS_WIDTH-1:0] d_wdata,
    output logic                 d_wdata_ready,
    output logic                 m_raddr_valid,
    output logic [BUS_WIDTH-1:0] m_raddr,
    input  logic                 m_raddr_ready,
    input  logic                 m_rdata_valid,
    input  logic [BUS_WIDTH-1:0] m_rdata,
    output logic                 m_rdata_ready,
    output logic                 m_waddr_valid,
    output logic [BUS_WIDTH-1:0] m_waddr,
    input  logic                 m_waddr_ready,
    output logic                 m_wdata_valid,
    output logic [BUS_WIDTH-1:0] m_wdata,
    input  logic                 m_wdata_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t               state;
    state_t               state_next;
    logic                 owner;
    logic                 last_grant;
    logic [BUS_WIDTH-1:0] addr_q;
    logic                 grant;
    logic                 accept;
    logic [BUS_WIDTH-1:0] grant_addr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWNER_I;
            // NOTE: addr_q is a single register, not a memory, so resetting it is
            // cheap and keeps m_raddr deterministic straight out of reset.
            addr_q     <= '0;
            last_grant <= OWNER_D;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q     <= grant_addr;
                owner      <= grant;
                last_grant <= grant;
            end
        end
    end

    // Contested requests go to whichever master was not served last.
    always_comb begin
        if (i_raddr_valid && d_raddr_valid) begin
            grant = ~last_grant;
        end else begin
            grant = d_raddr_valid ? OWNER_D : OWNER_I;
        end
        grant_addr = (grant == OWNER_D) ? d_raddr : i_raddr;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        i_raddr_ready = 1'b0;
        d_raddr_ready = 1'b0;
        i_rdata_valid = 1'b0;
        d_rdata_valid = 1'b0;
        m_raddr_valid = 1'b0;
        m_rdata_ready = 1'b0;

        // Everything is gated by rst so the block is silent while held in reset.
        case (state)
            IDLE: begin
                if (rst && (i_raddr_valid || d_raddr_valid)) begin
                    accept        = 1'b1;
                    i_raddr_ready = (grant == OWNER_I);
                    d_raddr_ready = (grant == OWNER_D);
                    state_next    = ADDR;
                end
            end
            ADDR: begin
                m_raddr_valid = rst;
                if (m_raddr_ready) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                m_rdata_ready = rst && ((owner == OWNER_D) ? d_rdata_ready : i_rdata_ready);
                i_rdata_valid = rst && (owner == OWNER_I) && m_rdata_valid;
                d_rdata_valid = rst && (owner == OWNER_D) && m_rdata_valid;
                if (m_rdata_valid && m_rdata_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign m_raddr = addr_q;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

    assign m_waddr_valid = rst && d_waddr_valid;
    assign m_waddr       = rst ? d_waddr : '0;
    assign d_waddr_ready = rst && m_waddr_ready;
    assign m_wdata_valid = rst && d_wdata_valid;
    assign m_wdata       = rst ? d_wdata : '0;
    assign d_wdata_ready = rst && m_wdata_ready;

endmodule

// File: tb/tb_copperv_bus_arbiter.sv
// Directed bench for copperv_bus_arbiter: a cycle-by-cycle vector table for reset,
// single reads and round-robin alternation, then hand sequences for stalls, reset mid-read and writes.
module tb_copperv_bus_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_raddr_valid, i_raddr_ready, i_rdata_valid, i_rdata_ready;
    logic [W-1:0] i_raddr, i_rdata;
    logic         d_raddr_valid, d_raddr_ready, d_rdata_valid, d_rdata_ready;
    logic [W-1:0] d_raddr, d_rdata;
    logic         d_waddr_valid, d_waddr_ready, d_wdata_valid, d_wdata_ready;
    logic [W-1:0] d_waddr, d_wdata;
    logic         m_raddr_valid, m_raddr_ready, m_rdata_valid, m_rdata_ready;
    logic [W-1:0] m_raddr, m_rdata;
    logic         m_waddr_valid, m_waddr_ready, m_wdata_valid, m_wdata_ready;
    logic [W-1:0] m_waddr, m_wdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    copperv_bus_arbiter #(.BUS_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .i_raddr_valid(i_raddr_valid), .i_raddr(i_raddr), .i_raddr_ready(i_raddr_ready),
        .i_rdata_valid(i_rdata_valid), .i_rdata(i_rdata), .i_rdata_ready(i_rdata_ready),
        .d_raddr_valid(d_raddr_valid), .d_raddr(d_raddr), .d_raddr_ready(d_raddr_ready),
        .d_rdata_valid(d_rdata_valid), .d_rdata(d_rdata), .d_rdata_ready(d_rdata_ready),
        .d_waddr_valid(d_waddr_valid), .d_waddr(d_waddr), .d_waddr_ready(d_waddr_ready),
        .d_wdata_valid(d_wdata_valid), .d_wdata(d_wdata), .d_wdata_ready(d_wdata_ready),
        .m_raddr_valid(m_raddr_valid), .m_raddr(m_raddr), .m_raddr_ready(m_raddr_ready),
        .m_rdata_valid(m_rdata_valid), .m_rdata(m_rdata), .m_rdata_ready(m_rdata_ready),
        .m_waddr_valid(m_waddr_valid), .m_waddr(m_waddr), .m_waddr_ready(m_waddr_ready),
        .m_wdata_valid(m_wdata_valid), .m_wdata(m_wdata), .m_wdata_ready(m_wdata_ready)
    );

    typedef struct {
        logic         rst;
        logic         iv;
        logic [W-1:0] ia;
        logic         ir;
        logic         dv;
        logic [W-1:0] da;
        logic         dr;
        logic         mar;
        logic         mdv;
        logic [W-1:0] md;
        logic         e_iar;
        logic         e_dar;
        logic         e_mav;
        logic [W-1:0] e_ma;
        logic         e_irv;
        logic         e_drv;
        logic         e_mdr;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Read-side outputs; addresses and data are only compared when qualified by valid.
    task automatic check_rd(input string tag, input logic iar, input logic dar, input logic mav,
                            input logic [W-1:0] ma, input logic irv, input logic drv,
                            input logic mdr, input logic [W-1:0] md);
        check({tag, " i_raddr_ready"}, W'(i_raddr_ready), W'(iar));
        check({tag, " d_raddr_ready"}, W'(d_raddr_ready), W'(dar));
        check({tag, " m_raddr_valid"}, W'(m_raddr_valid), W'(mav));
        if (mav) check({tag, " m_raddr"}, m_raddr, ma);
        check({tag, " i_rdata_valid"}, W'(i_rdata_valid), W'(irv));
        check({tag, " d_rdata_valid"}, W'(d_rdata_valid), W'(drv));
        check({tag, " m_rdata_ready"}, W'(m_rdata_ready), W'(mdr));
        if (irv) check({tag, " i_rdata"}, i_rdata, md);
        if (drv) check({tag, " d_rdata"}, d_rdata, md);
    endtask

    task automatic check_wr(input string tag, input logic mwav, input logic [W-1:0] mwa,
                            input logic dwar, input logic mwdv, input logic [W-1:0] mwd,
                            input logic dwdr);
        check({tag, " m_waddr_valid"}, W'(m_waddr_valid), W'(mwav));
        if (mwav) check({tag, " m_waddr"}, m_waddr, mwa);
        check({tag, " d_waddr_ready"}, W'(d_waddr_ready), W'(dwar));
        check({tag, " m_wdata_valid"}, W'(m_wdata_valid), W'(mwdv));
        if (mwdv) check({tag, " m_wdata"}, m_wdata, mwd);
        check({tag, " d_wdata_ready"}, W'(d_wdata_ready), W'(dwdr));
    endtask

    // Inputs change 1 time unit after posedge; outputs are sampled at the following negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst iv ia        ir dv da        dr mar mdv md            iar dar mav ma        irv drv mdr
        vecs[0]  = '{0, 1, 32'h100,  1, 0, 32'h0,    1, 1,  1, 32'h1234,     0,  0,  0, 32'h0,    0,  0,  0};
        vecs[1]  = '{0, 1, 32'h100,  1, 0, 32'h0,    1, 1,  1, 32'h1234,     0,  0,  0, 32'h0,    0,  0,  0};
        vecs[2]  = '{0, 1, 32'h100,  1, 0, 32'h0,    1, 1,  1, 32'h1234,     0,  0,  0, 32'h0,    0,  0,  0};
        vecs[3]  = '{1, 0, 32'h0,    1, 0, 32'h0,    1, 1,  1, 32'h1234,     0,  0,  0, 32'h0,    0,  0,  0};
        vecs[4]  = '{1, 1, 32'h100,  1, 0, 32'h0,    1, 1,  0, 32'h0,        1,  0,  0, 32'h0,    0,  0,  0};
        vecs[5]  = '{1, 0, 32'h0,    1, 0, 32'h0,    1, 1,  0, 32'h0,        0,  0,  1, 32'h100,  0,  0,  0};
        vecs[6]  = '{1, 0, 32'h0,    1, 0, 32'h0,    1, 1,  1, 32'hDEADBEEF, 0,  0,  0, 32'h0,    1,  0,  1};
        vecs[7]  = '{1, 1, 32'h0,    1, 1, 32'h2000, 1, 1,  0, 32'h0,        0,  1,  0, 32'h0,    0,  0,  0};
        vecs[8]  = '{1, 1, 32'h0,    1, 1, 32'h2000, 1, 1,  0, 32'h0,        0,  0,  1, 32'h2000, 0,  0,  0};
        vecs[9]  = '{1, 1, 32'h0,    1, 1, 32'h2000, 1, 1,  1, 32'hAAAA0001, 0,  0,  0, 32'h0,    0,  1,  1};
        vecs[10] = '{1, 1, 32'h0,    1, 1, 32'h2000, 1, 1,  0, 32'h0,        1,  0,  0, 32'h0,    0,  0,  0};
        vecs[11] = '{1, 1, 32'h0,    1, 1, 32'h2000, 1, 1,  0, 32'h0,        0,  0,  1, 32'h0,    0,  0,  0};
        vecs[12] = '{1, 1, 32'h0,    1, 1, 32'h2000, 1, 1,  1, 32'hBBBB0002, 0,  0,  0, 32'h0,    1,  0,  1};
        vecs[13] = '{1, 1, 32'h0,    1, 1, 32'h2000, 1, 1,  0, 32'h0,        0,  1,  0, 32'h0,    0,  0,  0};
        vecs[14] = '{1, 1, 32'h0,    1, 1, 32'h2000, 1, 1,  0, 32'h0,        0,  0,  1, 32'h2000, 0,  0,  0};
        vecs[15] = '{1, 1, 32'h0,    1, 1, 32'h2000, 1, 1,  1, 32'hCCCC0003, 0,  0,  0, 32'h0,    0,  1,  1};
        vecs[16] = '{1, 0, 32'h0,    1, 0, 32'h0,    1, 1,  0, 32'h0,        0,  0,  0, 32'h0,    0,  0,  0};

        rst = 1'b0;
        i_raddr_valid = 1'b0; i_raddr = '0; i_rdata_ready = 1'b0;
        d_raddr_valid = 1'b0; d_raddr = '0; d_rdata_ready = 1'b0;
        d_waddr_valid = 1'b0; d_waddr = '0; d_wdata_valid = 1'b0; d_wdata = '0;
        m_raddr_ready = 1'b0; m_rdata_valid = 1'b0; m_rdata = '0;
        m_waddr_ready = 1'b0; m_wdata_ready = 1'b0;

        for (int k = 0; k < 17; k++) begin
            tick();
            rst           = vecs[k].rst;
            i_raddr_valid = vecs[k].iv;
            i_raddr       = vecs[k].ia;
            i_rdata_ready = vecs[k].ir;
            d_raddr_valid = vecs[k].dv;
            d_raddr       = vecs[k].da;
            d_rdata_ready = vecs[k].dr;
            m_raddr_ready = vecs[k].mar;
            m_rdata_valid = vecs[k].mdv;
            m_rdata       = vecs[k].md;
            @(negedge clk);
            check_rd($sformatf("vec%0d", k), vecs[k].e_iar, vecs[k].e_dar, vecs[k].e_mav,
                     vecs[k].e_ma, vecs[k].e_irv, vecs[k].e_drv, vecs[k].e_mdr, vecs[k].md);
        end

        // d read with the memory address channel stalled; i keeps requesting but is not granted.
        tick();
        d_raddr_valid = 1'b1; d_raddr = 32'h3000; m_raddr_ready = 1'b0;
        @(negedge clk);
        check_rd("stall_accept", 0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            d_raddr_valid = 1'b0; i_raddr_valid = 1'b1; i_raddr = 32'h500;
            @(negedge clk);
            check_rd($sformatf("addr_stall%0d", k), 0, 0, 1, 32'h3000, 0, 0, 0, 32'h0);
        end
        tick();
        m_raddr_ready = 1'b1;
        @(negedge clk);
        check_rd("addr_go", 0, 0, 1, 32'h3000, 0, 0, 0, 32'h0);

        // d holds off its read data while memory presents it.
        for (int k = 0; k < 3; k++) begin
            tick();
            m_raddr_ready = 1'b0; m_rdata_valid = 1'b1; m_rdata = 32'hD00D; d_rdata_ready = 1'b0;
            @(negedge clk);
            check_rd($sformatf("data_stall%0d", k), 0, 0, 0, 32'h0, 0, 1, 0, 32'hD00D);
        end
        tick();
        d_rdata_ready = 1'b1;
        @(negedge clk);
        check_rd("data_go", 0, 0, 0, 32'h0, 0, 1, 1, 32'hD00D);

        // The pending i request is granted only once the FSM is back in IDLE.
        tick();
        m_rdata_valid = 1'b0;
        @(negedge clk);
        check_rd("i_after_stall", 1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        tick();
        i_raddr_valid = 1'b0; m_raddr_ready = 1'b1;
        @(negedge clk);
        check_rd("i_addr", 0, 0, 1, 32'h500, 0, 0, 0, 32'h0);
        tick();
        m_raddr_ready = 1'b0; m_rdata_valid = 1'b1; m_rdata = 32'h600D;
        @(negedge clk);
        check_rd("i_data", 0, 0, 0, 32'h0, 1, 0, 1, 32'h600D);

        // d read abandoned by reset in DATA; a late m_rdata_valid must be ignored.
        tick();
        m_rdata_valid = 1'b0; d_raddr_valid = 1'b1; d_raddr = 32'h4000;
        @(negedge clk);
        check_rd("rst_accept", 0, 1, 0, 32'h0, 0, 0, 0, 32'h0);
        tick();
        d_raddr_valid = 1'b0; m_raddr_ready = 1'b1;
        @(negedge clk);
        check_rd("rst_addr", 0, 0, 1, 32'h4000, 0, 0, 0, 32'h0);
        tick();
        m_raddr_ready = 1'b0;
        @(negedge clk);
        check_rd("rst_data_wait", 0, 0, 0, 32'h0, 0, 0, 1, 32'h0);
        tick();
        rst = 1'b0; m_rdata_valid = 1'b1; m_rdata = 32'h77;
        d_waddr_valid = 1'b1; d_waddr = 32'h40; d_wdata_valid = 1'b1; d_wdata = 32'h55;
        m_waddr_ready = 1'b1; m_wdata_ready = 1'b1;
        @(negedge clk);
        check_rd("in_reset", 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        check_wr("in_reset", 0, 32'h0, 0, 0, 32'h0, 0);
        tick();
        rst = 1'b1; m_waddr_ready = 1'b1; m_wdata_ready = 1'b0;
        @(negedge clk);
        check_rd("late_data", 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        check_wr("write_a", 1, 32'h40, 1, 1, 32'h55, 0);
        tick();
        d_waddr_valid = 1'b0; m_waddr_ready = 1'b0; m_wdata_ready = 1'b1;
        @(negedge clk);
        check_wr("write_b", 0, 32'h0, 0, 1, 32'h55, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
